// File: rtl/elliot_activation_pipe_if.sv
// Handshake bundle for the Elliott activation unit.
// master = producer/consumer side, slave = the unit.
interface elliot_activation_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, x, mode, out_ready,
    input  in_ready, out_valid, y, busy, done
  );

  modport slave (
    input  in_valid, x, mode, out_ready,
    output in_ready, out_valid, y, busy, done
  );
endinterface

// File: rtl/elliot_activation_pipe.sv
// Elliott activation y = x/(1+|x|), bipolar or unipolar,
// with a radix-2 restoring divider and valid/ready handshake.
module elliot_activation_pipe #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input logic clk,
  input logic reset,
  elliot_activation_pipe_if.slave io
);

  localparam int CW = $clog2(FRAC + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam logic [WIDTH-1:0] ONE =
    {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;

  logic [1:0]       state;
  logic             sign;
  logic             mode_r;
  logic             done_r;
  logic [WIDTH:0]   d;
  logic [WIDTH+1:0] rem;
  logic [FRAC-1:0]  q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] qs;
  logic [WIDTH-1:0] y_r;

  logic [WIDTH-1:0] a_in;
  logic [WIDTH+1:0] t;
  logic             fit;
  logic [WIDTH-1:0] q_ext;
  logic [WIDTH-1:0] uni;

  // magnitude of x, one divider step, and output shaping
  always_comb begin
    a_in  = io.x[WIDTH-1] ? -io.x : io.x;
    t     = rem << 1;
    fit   = (t >= {1'b0, d});
    q_ext = {{(WIDTH-FRAC){1'b0}}, q};
    uni   = $signed(ONE + qs) >>> 1;
  end

  // FSM: accept, divide FRAC steps, sign, shape, hold for consumer
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      sign   <= 1'b0;
      mode_r <= 1'b0;
      done_r <= 1'b0;
      d      <= '0;
      rem    <= '0;
      q      <= '0;
      cnt    <= '0;
      qs     <= '0;
      y_r    <= '0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (io.in_valid) begin
            sign   <= io.x[WIDTH-1];
            mode_r <= io.mode;
            d      <= {1'b0, a_in} + {1'b0, ONE};
            rem    <= {2'b00, a_in};
            q      <= '0;
            cnt    <= '0;
            state  <= S_DIV;
          end
        end
        S_DIV: begin
          if (cnt == CW'(FRAC)) begin
            qs    <= sign ? -q_ext : q_ext;
            state <= S_FIN;
          end else begin
            rem <= fit ? t - {1'b0, d} : t;
            q   <= FRAC'({q, fit});
            cnt <= cnt + CW'(1);
          end
        end
        S_FIN: begin
          y_r    <= mode_r ? uni : qs;
          done_r <= 1'b1;
          state  <= S_OUT;
        end
        S_OUT: begin
          if (io.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign io.in_ready  = (state == S_IDLE);
  assign io.out_valid = (state == S_OUT);
  assign io.busy      = (state != S_IDLE);
  assign io.done      = done_r;
  assign io.y         = y_r;

endmodule

// File: tb/tb_elliot_activation_pipe.sv
// Directed and random checks for elliot_activation_pipe,
// WIDTH=32, FRAC=16.
module tb_elliot_activation_pipe;

  localparam int W = 32;
  localparam int F = 16;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  elliot_activation_pipe_if #(.WIDTH(W)) io ();

  elliot_activation_pipe #(
    .WIDTH(W),
    .FRAC (F)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (io)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag,
                      input logic obs,
                      input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_y(
    input logic [31:0] xv,
    input logic m
  );
    logic [31:0]        av;
    longint unsigned    num;
    longint unsigned    den;
    longint unsigned    qq;
    logic signed [31:0] qsv;
    logic signed [31:0] u;
    av  = xv[31] ? -xv : xv;
    num = {32'd0, av} << 16;
    den = 64'h10000 + {32'd0, av};
    qq  = num / den;
    qsv = xv[31] ? -qq[31:0] : qq[31:0];
    u   = (32'sh10000 + qsv) >>> 1;
    return m ? u : qsv;
  endfunction

  task automatic do_op(input string tag,
                       input logic [31:0] xv,
                       input logic m,
                       input logic [31:0] ev,
                       input bit rnd);
    int g;
    int lat;
    int st;
    io.x        = xv;
    io.mode     = m;
    io.in_valid = 1'b1;
    io.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    g = 0;
    while (!io.in_ready && g < 40) begin
      tick;
      g++;
    end
    chkb({tag, " accept"}, io.in_ready, 1'b1);
    tick;
    io.in_valid = 1'b0;
    io.x        = $urandom;
    io.mode     = ~m;
    lat = 0;
    while (!io.out_valid && lat < 40) begin
      if (rnd) io.out_ready = 1'($urandom_range(0, 1));
      tick;
      lat++;
    end
    chk ({tag, " latency"}, lat, 18);
    chkb({tag, " done"}, io.done, 1'b1);
    chk ({tag, " y"}, io.y, ev);
    chkb({tag, " in_ready"}, io.in_ready, 1'b0);
    st = 0;
    do begin
      if (rnd)
        io.out_ready = (st >= 6) ? 1'b1
                     : 1'($urandom_range(0, 1));
      tick;
      if (io.out_valid) begin
        st++;
        chk ({tag, " y hold"}, io.y, ev);
        chkb({tag, " done low"}, io.done, 1'b0);
      end
    end while (io.out_valid && st < 10);
    chkb({tag, " released"}, io.out_valid, 1'b0);
    chkb({tag, " idle"}, io.in_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [31:0] xv;
    logic m;

    reset        = 1'b1;
    io.in_valid  = 1'b0;
    io.x         = '0;
    io.mode      = 1'b0;
    io.out_ready = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    chkb("rst in_ready", io.in_ready, 1'b1);
    chkb("rst out_valid", io.out_valid, 1'b0);
    chkb("rst busy", io.busy, 1'b0);
    chkb("rst done", io.done, 1'b0);
    chk ("rst y", io.y, 32'h0);

    do_op("bip +1", 32'h00010000, 1'b0,
          32'h00008000, 1'b0);
    do_op("bip -1", 32'hFFFF0000, 1'b0,
          32'hFFFF8000, 1'b0);
    do_op("bip +3", 32'h00030000, 1'b0,
          32'h0000C000, 1'b0);
    do_op("uni +1", 32'h00010000, 1'b1,
          32'h0000C000, 1'b0);
    do_op("uni 0", 32'h00000000, 1'b1,
          32'h00008000, 1'b0);
    do_op("bip 0", 32'h00000000, 1'b0,
          32'h00000000, 1'b0);
    do_op("uni -1", 32'hFFFF0000, 1'b1,
          32'h00004000, 1'b0);
    do_op("bip min", 32'h80000000, 1'b0,
          32'hFFFF0002, 1'b0);
    do_op("uni min", 32'h80000000, 1'b1,
          32'h00000001, 1'b0);
    do_op("bip max", 32'h7FFFFFFF, 1'b0,
          32'h0000FFFE, 1'b0);

    io.out_ready = 1'b0;
    io.x         = 32'h00030000;
    io.mode      = 1'b0;
    io.in_valid  = 1'b1;
    chkb("bp accept", io.in_ready, 1'b1);
    tick;
    io.in_valid = 1'b0;
    g = 0;
    while (!io.out_valid && g < 40) begin
      tick;
      g++;
    end
    chkb("bp out_valid", io.out_valid, 1'b1);
    chk ("bp y", io.y, 32'h0000C000);
    for (int i = 0; i < 10; i++) begin
      io.in_valid = 1'(i % 2);
      io.x        = 32'h00010000;
      tick;
      chkb("bp stall valid", io.out_valid, 1'b1);
      chk ("bp stall y", io.y, 32'h0000C000);
      chkb("bp stall ready", io.in_ready, 1'b0);
      chkb("bp stall busy", io.busy, 1'b1);
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    tick;
    chkb("bp release valid", io.out_valid, 1'b0);
    chkb("bp release ready", io.in_ready, 1'b1);
    chk ("bp release y", io.y, 32'h0000C000);
    do_op("bp next", 32'hFFFF0000, 1'b0,
          32'hFFFF8000, 1'b0);

    io.x        = 32'h00030000;
    io.mode     = 1'b1;
    io.in_valid = 1'b1;
    chkb("mid accept", io.in_ready, 1'b1);
    tick;
    io.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    chkb("mid busy", io.busy, 1'b1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chkb("mid out_valid", io.out_valid, 1'b0);
    chk ("mid y", io.y, 32'h0);
    chkb("mid in_ready", io.in_ready, 1'b1);
    chkb("mid busy clr", io.busy, 1'b0);
    do_op("mid fresh", 32'h00010000, 1'b0,
          32'h00008000, 1'b0);

    for (int i = 0; i < 100; i++) begin
      xv = $urandom;
      if (i % 2 == 1)
        xv = {{12{xv[31]}}, xv[19:0]};
      m = 1'($urandom_range(0, 1));
      do_op($sformatf("rnd%0d", i), xv, m,
            ref_y(xv, m), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
